// File: rtl/program_memory_loader.sv
// Boot-time program loader: packs a byte stream into 32-bit words
// and writes them to instruction memory while stalling the CPU.
module program_memory_loader #(
  parameter int MEMORY_DEPTH = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int COUNT_WIDTH  = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   Start,
  input  logic [COUNT_WIDTH-1:0] WordCount,
  input  logic [7:0]             ByteIn,
  input  logic                   ByteValid,
  output logic                   ByteReady,
  output logic                   MemWrite,
  output logic [DATA_WIDTH-1:0]  WriteAddress,
  output logic [DATA_WIDTH-1:0]  WriteData,
  output logic                   CpuStall,
  output logic                   Done,
  output logic                   Error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_e;

  localparam logic [COUNT_WIDTH-1:0] DEPTH_C =
    COUNT_WIDTH'(MEMORY_DEPTH);

  state_e                 state_q;
  logic [COUNT_WIDTH-1:0] count_q;
  logic [COUNT_WIDTH-1:0] index_q;
  logic [1:0]             bytes_q;
  logic [23:0]            asm_q;
  logic                   rdy_q;
  logic                   we_q;
  logic [DATA_WIDTH-1:0]  addr_q;
  logic [DATA_WIDTH-1:0]  data_q;
  logic                   stall_q;
  logic                   done_q;
  logic                   err_q;

  logic [31:0]            word_d;
  logic [COUNT_WIDTH-1:0] index_d;
  logic                   cnt_ok_d;

  // Big-endian packing: first byte ends up in bits [31:24].
  assign word_d   = {asm_q, ByteIn};
  assign index_d  = index_q + COUNT_WIDTH'(1);
  assign cnt_ok_d = (WordCount != '0) && (WordCount <= DEPTH_C);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
      index_q <= '0;
      bytes_q <= '0;
      asm_q   <= '0;
      rdy_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      stall_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      we_q <= 1'b0;
      unique case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (Start) begin
            done_q <= 1'b0;
            if (cnt_ok_d) begin
              count_q <= WordCount;
              index_q <= '0;
              bytes_q <= '0;
              asm_q   <= '0;
              rdy_q   <= 1'b1;
              stall_q <= 1'b1;
              err_q   <= 1'b0;
              state_q <= S_LOAD;
            end else begin
              err_q   <= 1'b1;
              state_q <= S_ERR;
            end
          end
        end
        S_LOAD: begin
          if (ByteValid) begin
            asm_q   <= word_d[23:0];
            bytes_q <= bytes_q + 2'd1;
            if (bytes_q == 2'd3) begin
              rdy_q   <= 1'b0;
              we_q    <= 1'b1;
              addr_q  <= DATA_WIDTH'({index_q, 2'b00});
              data_q  <= DATA_WIDTH'(word_d);
              state_q <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          index_q <= index_d;
          bytes_q <= '0;
          if (index_d == count_q) begin
            stall_q <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            rdy_q   <= 1'b1;
            state_q <= S_LOAD;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ByteReady    = rdy_q;
  assign MemWrite     = we_q;
  assign WriteAddress = addr_q;
  assign WriteData    = data_q;
  assign CpuStall     = stall_q;
  assign Done         = done_q;
  assign Error        = err_q;

endmodule

// File: tb/tb_program_memory_loader.sv
// Directed bench for program_memory_loader.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_program_memory_loader;

  logic        clk;
  logic        reset;
  logic        Start;
  logic [5:0]  WordCount;
  logic [7:0]  ByteIn;
  logic        ByteValid;
  logic        ByteReady;
  logic        MemWrite;
  logic [31:0] WriteAddress;
  logic [31:0] WriteData;
  logic        CpuStall;
  logic        Done;
  logic        Error;

  int tests;
  int fails;
  int pulses;
  int p0;

  program_memory_loader dut (
    .clk         (clk),
    .reset       (reset),
    .Start       (Start),
    .WordCount   (WordCount),
    .ByteIn      (ByteIn),
    .ByteValid   (ByteValid),
    .ByteReady   (ByteReady),
    .MemWrite    (MemWrite),
    .WriteAddress(WriteAddress),
    .WriteData   (WriteData),
    .CpuStall    (CpuStall),
    .Done        (Done),
    .Error       (Error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (MemWrite === 1'b1) pulses++;
  endtask

  task automatic start(input logic [5:0] wc);
    Start = 1'b1;
    WordCount = wc;
    tick();
    Start = 1'b0;
  endtask

  // Feed one word MSB first, optionally with an idle cycle before
  // each byte, then check the write cycle and the cycle after it.
  task automatic run_word(input logic [31:0] w,
                          input logic [31:0] addr,
                          input bit gap);
    for (int i = 0; i < 4; i++) begin
      if (gap) begin
        ByteValid = 1'b0;
        ByteIn = 8'hEE;
        tick();
      end
      ByteIn = w[31-8*i -: 8];
      ByteValid = 1'b1;
      tick();
    end
    ByteValid = 1'b1;
    ByteIn = 8'h99;
    check("wr_en", MemWrite, 1);
    check("wr_addr", WriteAddress, addr);
    check("wr_data", WriteData, w);
    check("wr_stall", CpuStall, 1);
    check("wr_rdy", ByteReady, 0);
    tick();
    ByteValid = 1'b0;
    check("wr_off", MemWrite, 0);
    check("addr_hold", WriteAddress, addr);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    pulses = 0;
    reset = 1'b0;
    Start = 1'b0;
    WordCount = '0;
    ByteIn = '0;
    ByteValid = 1'b0;
    tick();
    tick();
    check("rst_we", MemWrite, 0);
    check("rst_rdy", ByteReady, 0);
    check("rst_addr", WriteAddress, 0);
    check("rst_data", WriteData, 0);
    check("rst_stall", CpuStall, 0);
    check("rst_done", Done, 0);
    check("rst_err", Error, 0);
    reset = 1'b1;
    tick();

    // Reset in the middle of word 0
    start(6'd1);
    check("ld_rdy", ByteReady, 1);
    check("ld_stall", CpuStall, 1);
    ByteValid = 1'b1;
    ByteIn = 8'hAA;
    tick();
    ByteIn = 8'hBB;
    tick();
    ByteValid = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("mid_rdy", ByteReady, 0);
    check("mid_stall", CpuStall, 0);
    check("mid_we", MemWrite, 0);
    check("mid_done", Done, 0);
    #2 reset = 1'b1;
    tick();
    start(6'd1);
    run_word(32'h11223344, 32'h0, 1'b0);
    check("rr_done", Done, 1);

    // Single word, back-to-back bytes
    p0 = pulses;
    start(6'd1);
    check("sw_done_clr", Done, 0);
    run_word(32'h20080005, 32'h0, 1'b0);
    check("sw_done", Done, 1);
    check("sw_stall", CpuStall, 0);
    check("sw_pulses", pulses - p0, 1);

    // Three words, ByteValid toggling
    p0 = pulses;
    start(6'd3);
    check("w3_stall", CpuStall, 1);
    run_word(32'h00500113, 32'h0, 1'b1);
    run_word(32'h00C00193, 32'h4, 1'b1);
    run_word(32'h002081B3, 32'h8, 1'b1);
    check("w3_done", Done, 1);
    check("w3_stall_off", CpuStall, 0);
    check("w3_pulses", pulses - p0, 3);

    // Illegal counts
    p0 = pulses;
    start(6'd0);
    check("e0_err", Error, 1);
    check("e0_done", Done, 0);
    check("e0_rdy", ByteReady, 0);
    check("e0_stall", CpuStall, 0);
    ByteValid = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    ByteValid = 1'b0;
    check("e0_rdy2", ByteReady, 0);
    start(6'd33);
    check("e33_err", Error, 1);
    ByteValid = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    ByteValid = 1'b0;
    check("e33_rdy", ByteReady, 0);
    check("err_pulses", pulses - p0, 0);

    // Start during LOAD is ignored
    p0 = pulses;
    start(6'd2);
    check("ig_err_clr", Error, 0);
    start(6'd5);
    run_word(32'hCAFEF00D, 32'h0, 1'b0);
    check("ig_mid_done", Done, 0);
    run_word(32'h12345678, 32'h4, 1'b0);
    check("ig_done", Done, 1);
    check("ig_pulses", pulses - p0, 2);

    // Full depth then reload
    p0 = pulses;
    start(6'd32);
    for (int i = 0; i < 32; i++)
      run_word(32'hA5000000 ^ (i * 32'h01010101),
               i * 4, i[0]);
    check("fd_addr", WriteAddress, 32'h7C);
    check("fd_done", Done, 1);
    check("fd_pulses", pulses - p0, 32);
    start(6'd1);
    check("re_done_clr", Done, 0);
    check("re_stall", CpuStall, 1);
    run_word(32'hDEADBEEF, 32'h0, 1'b0);
    check("re_done", Done, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/program_memory_loader.md
Name: program_memory_loader

Overview:
- Boot-time configurator for the instruction memory: takes a byte stream over a valid/ready handshake and packs it into 32-bit words.
- Issues one write per word to the instruction memory write port, at byte addresses 0, 4, 8, … (word index = address[31:2]).
- Holds the CPU in stall while loading, then releases it and flags completion or error.
- Sits between the host/UART byte source and the program memory, ahead of instruction fetch.

Parameters:
- MEMORY_DEPTH, 32, number of 32-bit words in the program memory.
- DATA_WIDTH, 32, instruction and address width. Fixed at 32: the block packs 4 bytes per word.
- COUNT_WIDTH, 6, width of WordCount; must hold MEMORY_DEPTH.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous active-low reset.
- Start  input  1  single-cycle load request; WordCount is sampled on the same cycle.
- WordCount  input  COUNT_WIDTH  number of words to load.
- ByteIn  input  8  stream byte.
- ByteValid  input  1  ByteIn is valid.
- ByteReady  output  1  loader accepts a byte this cycle.
- MemWrite  output  1  one-cycle write strobe to program memory.
- WriteAddress  output  DATA_WIDTH  byte address (index*4).
- WriteData  output  DATA_WIDTH  assembled instruction word.
- CpuStall  output  1  freezes PC/fetch while high.
- Done  output  1  sticky: load completed.
- Error  output  1  sticky: illegal WordCount.

Behaviour:
- Reset (reset=0, asynchronous):
  - State = IDLE.
  - All outputs 0; byte counter, word index and assembly register cleared.
  - A partial word in progress is discarded.
- States: IDLE, LOAD, WRITE, DONE, ERR.
- IDLE:
  - ByteReady=0, CpuStall=0.
  - Start with 1 ≤ WordCount ≤ MEMORY_DEPTH: latch WordCount, index=0, byte count=0, go to LOAD.
  - Start with WordCount=0 or WordCount>MEMORY_DEPTH: go to ERR.
- LOAD:
  - ByteReady=1, CpuStall=1.
  - A byte is accepted on any edge where ByteValid & ByteReady.
  - Accepted byte: assembly = {assembly[23:0], ByteIn}. Big-endian, so the first byte becomes bits [31:24], matching .dat hex order.
  - On the 4th accepted byte: go to WRITE. ByteReady is driven 0 in WRITE, so a fifth byte cannot be taken in that cycle.
- WRITE (exactly 1 cycle):
  - MemWrite=1, WriteAddress=index<<2, WriteData=assembled word, CpuStall=1.
  - Next edge: index+1, byte count=0.
  - If index+1 == latched WordCount, go to DONE; otherwise go to LOAD.
- DONE:
  - Done=1, CpuStall=0, ByteReady=0.
  - A new Start clears Done and applies the IDLE rules.
- ERR:
  - Error=1, CpuStall=0, no writes ever issued.
  - A new Start clears Error and applies the IDLE rules.
- Start in LOAD/WRITE is ignored; WordCount changes mid-load have no effect.
- Timing:
  - Minimum per word: 4 accepted-byte cycles + 1 write cycle = 5 cycles.
  - ByteValid gaps simply extend LOAD; no timeout.
- Index never exceeds WordCount-1, so WriteAddress ≤ (MEMORY_DEPTH-1)*4. No wrap-around is possible.
- MemWrite, WriteAddress and WriteData are registered. WriteAddress and WriteData are held at their last values outside WRITE; only MemWrite qualifies them.

Test Plan:
- Reset mid-load: after 2 bytes of word 0, pulse reset low → all outputs 0, state IDLE. A new Start writes the first complete word at address 0 using only post-reset bytes.
- Single word: Start, WordCount=1, bytes 0x20,0x08,0x00,0x05 back-to-back → 4 cycles later MemWrite=1 for exactly one cycle with WriteAddress=0x0, WriteData=0x20080005. Next cycle Done=1, CpuStall=0.
- Three words with ByteValid toggling every other cycle → writes at 0x0, 0x4, 0x8 with the correct packing. CpuStall=1 from the cycle after Start until the cycle after the 3rd write. Exactly 3 MemWrite pulses.
- Illegal counts: WordCount=0, and separately WordCount=33 → Error=1, MemWrite never asserted, ByteReady stays 0.
- Start pulsed during LOAD with a different WordCount → ignored; load completes with the original count.
- Full depth: WordCount=32 → last write at 0x7C, then Done=1. A second Start with WordCount=1 clears Done and rewrites address 0x0.
